// File: rtl/fifo_pin_host_if.sv
// Stream-side bundle for fifo_pin_host: a write stream into the pin FIFO and a
// read stream carrying popped bytes back out.
//
// Signals:
//   wr_valid / wr_data / wr_ready : write request, payload, accept (host -> client)
//   rd_valid / rd_data / rd_ready : popped byte presented by host, taken by client
//
// Modports:
//   master : the client that produces writes and consumes read data
//   slave  : the host (fifo_pin_host) that accepts writes and presents read data
interface fifo_pin_host_if #(
  parameter int unsigned DATA_W = 8
);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

endinterface

// File: rtl/fifo_pin_host.sv
// Host-side driver for the 8-bit pin-level FIFO tile.
//
// Turns a write stream and a read stream into single-cycle push/pop pin strobes,
// paced so that the FIFO status pins are only looked at once they are trustworthy
// again, and captures popped bytes into a one-entry read buffer.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : stream bundle (slave side): wr_valid/wr_data/wr_ready,
//                rd_valid/rd_data/rd_ready
//   pin_data   : write data to FIFO, holds last pushed value
//   pin_push   : one-cycle push strobe
//   pin_pop    : one-cycle pop strobe
//   pin_q      : read data from FIFO, valid RD_LAT cycles after the pop cycle
//   pin_full   : FIFO full status (only evaluated while idle)
//   pin_empty  : FIFO empty status (only evaluated while idle)
//   push_cnt   : pushes issued, wraps modulo 256
//   pop_cnt    : pops issued, wraps modulo 256
module fifo_pin_host #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STATUS_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  fifo_pin_host_if.slave    bus,
  output logic [DATA_W-1:0] pin_data,
  output logic              pin_push,
  output logic              pin_pop,
  input  logic [DATA_W-1:0] pin_q,
  input  logic              pin_full,
  input  logic              pin_empty,
  output logic [7:0]        push_cnt,
  output logic [7:0]        pop_cnt
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StPush   = 3'd1;
  localparam logic [2:0] StPop    = 3'd2;
  localparam logic [2:0] StWaitRd = 3'd3;
  localparam logic [2:0] StSettle = 3'd4;

  localparam logic OpPush = 1'b0;
  localparam logic OpPop  = 1'b1;

  localparam logic [2:0] RdLat     = 3'(RD_LAT);
  localparam logic [2:0] StatusLat = 3'(STATUS_LAT);

  logic [2:0]        state_q, state_d;
  logic              last_op_q, last_op_d;
  logic [2:0]        settle_cnt_q, settle_cnt_d;
  // Read-latency tracker: runs from the pop grant independently of the FSM so the
  // pin_q sample lands exactly RD_LAT cycles after the pop cycle.
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              cap_pend_q, cap_pend_d;
  logic [DATA_W-1:0] pin_data_q, pin_data_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [7:0]        push_cnt_q, push_cnt_d;
  logic [7:0]        pop_cnt_q, pop_cnt_d;

  logic in_idle;
  logic write_ok;
  logic read_ok;
  logic grant_push;
  logic grant_pop;

  // Status pins are only meaningful here; reset also blocks any grant.
  assign in_idle  = (state_q == StIdle) && !rst;
  assign write_ok = bus.wr_valid && !pin_full;
  assign read_ok  = !pin_empty && !rd_valid_q;

  // On a tie the op opposite to the last one wins.
  assign grant_push = in_idle && write_ok && (!read_ok || (last_op_q == OpPop));
  assign grant_pop  = in_idle && read_ok && !grant_push;

  assign bus.wr_ready = grant_push;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  assign pin_data = pin_data_q;
  assign pin_push = push_q;
  assign pin_pop  = pop_q;
  assign push_cnt = push_cnt_q;
  assign pop_cnt  = pop_cnt_q;

  always_comb begin
    state_d      = state_q;
    last_op_d    = last_op_q;
    settle_cnt_d = settle_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    cap_pend_d   = cap_pend_q;
    pin_data_d   = pin_data_q;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    push_cnt_d   = push_cnt_q;
    pop_cnt_d    = pop_cnt_q;

    // Consumer handshake; capture below can never coincide since a pop is only
    // issued with the buffer empty.
    if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end

    if (cap_pend_q) begin
      if (lat_cnt_q == 3'd0) begin
        rd_data_d  = pin_q;
        rd_valid_d = 1'b1;
        cap_pend_d = 1'b0;
      end else begin
        lat_cnt_d = lat_cnt_q - 3'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (grant_push) begin
          state_d    = StPush;
          push_d     = 1'b1;
          pin_data_d = bus.wr_data;
          push_cnt_d = push_cnt_q + 8'd1;
          last_op_d  = OpPush;
        end else if (grant_pop) begin
          state_d    = StPop;
          pop_d      = 1'b1;
          pop_cnt_d  = pop_cnt_q + 8'd1;
          last_op_d  = OpPop;
          lat_cnt_d  = RdLat;
          cap_pend_d = 1'b1;
        end
      end
      StPush: begin
        state_d      = StSettle;
        settle_cnt_d = StatusLat;
      end
      StPop: begin
        // lat_cnt_q still equals RD_LAT here; RD_LAT==1 skips WAIT_RD.
        if (lat_cnt_q <= 3'd1) begin
          state_d      = StSettle;
          settle_cnt_d = StatusLat;
        end else begin
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        // The sample cycle overlaps the first SETTLE cycle.
        if (lat_cnt_q <= 3'd1) begin
          state_d      = StSettle;
          settle_cnt_d = StatusLat;
        end
      end
      StSettle: begin
        if (settle_cnt_q <= 3'd1) begin
          state_d = StIdle;
        end else begin
          settle_cnt_d = settle_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_op_q    <= OpPop;
      settle_cnt_q <= 3'd0;
      lat_cnt_q    <= 3'd0;
      cap_pend_q   <= 1'b0;
      pin_data_q   <= '0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      push_cnt_q   <= 8'd0;
      pop_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_op_q    <= last_op_d;
      settle_cnt_q <= settle_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      cap_pend_q   <= cap_pend_d;
      pin_data_q   <= pin_data_d;
      push_q       <= push_d;
      pop_q        <= pop_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_q && pop_q));
      assert (!(pop_q && rd_valid_q));
    end
  end

endmodule

// File: doc/fifo_pin_host.md
Name: fifo_pin_host

Overview:
- Host-side driver for the 8-bit pin-level FIFO tile: the other end of the dedicated-pin push/pop interface.
- Converts two valid/ready streams (write-side and read-side) into single-cycle push/pop pin strobes with status-aware pacing.
- Captures popped data from the FIFO output pins.
- Used as an on-chip exerciser and as the reference host in the system bench.

Parameters:
DATA_W, 8, data width of pin_data/pin_q/wr_data/rd_data
RD_LAT, 1, cycles from the pin_pop cycle to valid pin_q (1..7)
STATUS_LAT, 1, cycles after any strobe before pin_full/pin_empty are trusted again (1..7)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
wr_valid  input  1  write request
wr_data  input  DATA_W  write payload
wr_ready  output  1  write accepted when wr_valid&&wr_ready
rd_valid  output  1  rd_data holds a popped byte
rd_data  output  DATA_W  popped byte
rd_ready  input  1  consumer takes byte when rd_valid&&rd_ready
pin_data  output  DATA_W  drives FIFO ui_in (write data)
pin_push  output  1  drives FIFO uio_in[0]; one-cycle push strobe
pin_pop  output  1  drives FIFO uio_in[1]; one-cycle pop strobe
pin_q  input  DATA_W  from FIFO uo_out (read data)
pin_full  input  1  from FIFO uio_out[2]
pin_empty  input  1  from FIFO uio_out[3]
push_cnt  output  8  pushes issued, wraps 255->0
pop_cnt  output  8  pops issued, wraps 255->0

Behaviour:
- Reset (rst=1 at edge): state IDLE, all outputs 0, rd buffer empty, counters 0, last_op=POP (write wins first tie). Applies in any state; strobes drop the next cycle; in-flight pop data is discarded, never presented.
- FSM states: IDLE, PUSH, POP, WAIT_RD, SETTLE. pin_push/pin_pop/pin_data are registered.
- IDLE eligibility:
  - write_ok = wr_valid && !pin_full
  - read_ok = !pin_empty && !rd_valid (one-entry buffer must be free)
- Tie (both eligible): grant the op opposite to last_op.
- wr_ready is combinational: 1 only in IDLE when the write is granted; 0 in all other states.
- Write handshake at edge n -> cycle n+1 is PUSH:
  - pin_push=1 for exactly one cycle; pin_data=captured wr_data.
  - push_cnt+1, last_op=PUSH, then SETTLE.
- pin_data holds its last pushed value until the next push (0 after reset).
- Pop grant at edge n -> cycle n+1 is POP:
  - pin_pop=1 for exactly one cycle; pop_cnt+1, last_op=POP.
  - Then WAIT_RD for RD_LAT-1 cycles (zero cycles when RD_LAT=1).
  - pin_q is sampled at the end of cycle n+1+RD_LAT.
  - rd_valid=1, rd_data=sample from cycle n+2+RD_LAT; then SETTLE.
- rd_valid/rd_data hold stable until rd_valid&&rd_ready; rd_valid clears the next cycle.
  - rd_ready while rd_valid=0 is ignored.
- SETTLE lasts STATUS_LAT cycles (down-counter), then IDLE. No strobes and no wr_ready during SETTLE.
- Minimum spacing between any two strobes: 1+STATUS_LAT idle-free cycles for a push; RD_LAT+STATUS_LAT cycles for a pop.
- Boundary behaviour:
  - pin_full or pin_empty changing outside IDLE is ignored; it is only evaluated in IDLE.
  - pin_push and pin_pop are never high in the same cycle.
  - A pop is never issued while rd_valid=1.
- Counter wrap: 8-bit modulo; no saturation.

Test Plan:
1. Reset: rst high 2 cycles, random inputs -> all outputs 0, wr_ready=0, counters 0; after release, IDLE with pin_full=0 and wr_valid=0 -> no strobes.
2. Single push: pin_full=0, wr_valid=1, wr_data=0xA5 at cycle 0 -> wr_ready=1 in cycle 0; cycle 1 pin_push=1, pin_data=0xA5; cycle 2 pin_push=0, pin_data stays 0xA5, push_cnt=1; wr_ready=0 through the STATUS_LAT=1 SETTLE cycle.
3. Full backpressure: pin_full=1, wr_valid=1 for 10 cycles -> wr_ready=0, no pin_push; drop pin_full -> wr_ready=1 the same cycle, push in the next cycle.
4. Pop with RD_LAT=1: pin_empty=0, rd_ready=0, pop granted cycle 0 -> pin_pop=1 in cycle 1; pin_q=0x3C in cycle 2 -> rd_valid=1, rd_data=0x3C from cycle 3, held 20 cycles with no further pin_pop; rd_ready=1 -> rd_valid=0 the next cycle, then a new pop is allowed.
5. Arbitration: write_ok and read_ok continuously true, rd_ready=1 -> strobe order PUSH, POP, PUSH, POP; 300 ops -> push_cnt=150-150 mod 256 wrap checked (push_cnt=150, pop_cnt=150); 600 ops -> counters wrap to 44.
6. Reset mid-pop: assert rst in the cycle after pin_pop -> rd_valid never asserts; pop_cnt=0; the first post-reset tie grants PUSH.
